// File: rtl/mux_8x1_core.sv
// Purpose : 8:1 lane selector; y picks lane[sel] from a packed 8-lane bus.
// Latency : 1 cycle with MUX_8X1_OUTREG_EN defined, 0 cycles otherwise.
// Backpressure: none; en=0 holds the registered output (registered build only).
//
// Configuration macro: MUX_8X1_OUTREG_EN
//   defined   -> output register with capture enable; y_valid sets on first capture.
//   undefined -> pure combinational mux; y_valid mirrors rst_n, en is ignored.
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (clears y and y_valid)
//   en      : capture enable for the output register
//   in      : 8 packed lanes, lane i = in[i*DATA_W +: DATA_W]
//   sel     : lane index 0..7
//   y       : selected lane
//   y_valid : y holds a captured value since the last reset
module mux_8x1_core #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [8*DATA_W-1:0]   in,
    input  logic [2:0]            sel,
    output logic [DATA_W-1:0]     y,
    output logic                  y_valid
);

    // Unpack the bus into an indexable lane array so the select is a single
    // 8:1 mux level with no multiply on the index.
    logic [DATA_W-1:0] lanes [8];
    logic [DATA_W-1:0] next_y;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lanes[i] = in[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        next_y = lanes[sel];
    end

`ifdef MUX_8X1_OUTREG_EN

    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] y_d;
    logic              y_valid_q;
    logic              y_valid_d;

    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (en) begin
            y_d       = next_y;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

`else

    // Output is forced to zero while reset is asserted so both builds present
    // the same reset values; otherwise it follows the selection directly.
    assign y       = rst_n ? next_y : '0;
    assign y_valid = rst_n;

    // clk and en have no function in this build.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, en};

`endif

endmodule

// File: tb/tb_mux_8x1_core.sv
module tb_mux_8x1_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;

    logic [7:0]  in1;
    logic [2:0]  sel1;
    logic [0:0]  y1;
    logic        yv1;

    logic [63:0] in8;
    logic [2:0]  sel8;
    logic [7:0]  y8;
    logic        yv8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_8x1_core #(.DATA_W(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in1),
        .sel    (sel1),
        .y      (y1),
        .y_valid(yv1)
    );

    mux_8x1_core #(.DATA_W(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in8),
        .sel    (sel8),
        .y      (y8),
        .y_valid(yv8)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        in1   = 8'hFF;
        sel1  = 3'd0;
        in8   = 64'hFFFF_FFFF_FFFF_FFFF;
        sel8  = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (y1 !== 1'b0) begin errors++; $display("FAIL reset_y1: got %b want 0", y1); end
        checks++;
        if (yv1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", yv1); end
        checks++;
        if (y8 !== 8'h00) begin errors++; $display("FAIL reset_y8: got %h want 00", y8); end
        checks++;
        if (yv8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b want 0", yv8); end
        // Release with en=0: registered build must not flag valid yet.
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
`ifdef MUX_8X1_OUTREG_EN
        if (yv1 !== 1'b0) begin errors++; $display("FAIL valid_before_capture: got %b want 0", yv1); end
`else
        if (yv1 !== 1'b1) begin errors++; $display("FAIL valid_follows_rst: got %b want 1", yv1); end
`endif
    endtask

    task automatic test_lane_sweep();
        logic [7:0] exp_y;
        exp_y = 8'b01101011;   // y for sel=0..7 is bit sel: 1,1,0,1,0,1,1,0
        @(negedge clk);
        en  = 1'b1;
        in1 = 8'b01101011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sel1 = 3'(i);
`ifndef MUX_8X1_OUTREG_EN
            #1;
            checks++;
            if (y1 !== exp_y[i]) begin errors++; $display("FAIL sweep_comb sel=%0d: got %b want %b", i, y1, exp_y[i]); end
`endif
            @(posedge clk); #1;
            checks++;
            if (y1 !== exp_y[i]) begin errors++; $display("FAIL sweep sel=%0d: got %b want %b", i, y1, exp_y[i]); end
            checks++;
            if (yv1 !== 1'b1) begin errors++; $display("FAIL sweep_valid sel=%0d: got %b want 1", i, yv1); end
        end
    endtask

    task automatic test_hold();
        logic exp_hold;
        @(negedge clk);
        en   = 1'b1;
        in1  = 8'b01101011;
        sel1 = 3'd3;
        @(posedge clk); #1;
        checks++;
        if (y1 !== 1'b1) begin errors++; $display("FAIL hold_capture: got %b want 1", y1); end
        @(negedge clk);
        en   = 1'b0;
        sel1 = 3'd2;
        in1  = 8'h00;
`ifdef MUX_8X1_OUTREG_EN
        exp_hold = 1'b1;
`else
        exp_hold = 1'b0;
`endif
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (y1 !== exp_hold) begin errors++; $display("FAIL hold_y cycle=%0d: got %b want %b", c, y1, exp_hold); end
            checks++;
            if (yv1 !== 1'b1) begin errors++; $display("FAIL hold_valid cycle=%0d: got %b want 1", c, yv1); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en   = 1'b1;
        sel1 = 3'd0;
        in1  = 8'h01;
        @(posedge clk); #1;
        checks++;
        if (y1 !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", y1); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y1 !== 1'b0) begin errors++; $display("FAIL arst_y: got %b want 0", y1); end
        checks++;
        if (yv1 !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", yv1); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
`ifdef MUX_8X1_OUTREG_EN
        if (y1 !== 1'b0) begin errors++; $display("FAIL arst_release_before_edge: got %b want 0", y1); end
`else
        if (y1 !== 1'b1) begin errors++; $display("FAIL arst_release_comb: got %b want 1", y1); end
`endif
        @(posedge clk); #1;
        checks++;
        if (y1 !== 1'b1) begin errors++; $display("FAIL arst_first_capture: got %b want 1", y1); end
        checks++;
        if (yv1 !== 1'b1) begin errors++; $display("FAIL arst_first_valid: got %b want 1", yv1); end
    endtask

    task automatic test_wide_lanes();
        logic [7:0] exp_w [3];
        logic [2:0] sels  [3];
        sels[0] = 3'd5; exp_w[0] = 8'h55;
        sels[1] = 3'd0; exp_w[1] = 8'h00;
        sels[2] = 3'd7; exp_w[2] = 8'h77;
        @(negedge clk);
        en  = 1'b1;
        in8 = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sel8 = sels[k];
            @(posedge clk); #1;
            checks++;
            if (y8 !== exp_w[k]) begin errors++; $display("FAIL wide sel=%0d: got %h want %h", sels[k], y8, exp_w[k]); end
        end
        checks++;
        if (yv8 !== 1'b1) begin errors++; $display("FAIL wide_valid: got %b want 1", yv8); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        en   = 1'b1;
        in1  = 8'hFF;
        sel1 = 3'd0;
        @(posedge clk); #1;
        checks++;
        if (y1 !== 1'b1) begin errors++; $display("FAIL simul_first: got %b want 1", y1); end
        @(negedge clk);
        in1  = 8'h00;
        sel1 = 3'd7;
        @(posedge clk); #1;
        checks++;
        if (y1 !== 1'b0) begin errors++; $display("FAIL simul_second: got %b want 0", y1); end
        @(negedge clk);
        in1  = 8'h80;
        @(posedge clk); #1;
        checks++;
        if (y1 !== 1'b1) begin errors++; $display("FAIL simul_third: got %b want 1", y1); end
    endtask

    initial begin
        test_reset();
        test_lane_sweep();
        test_hold();
        test_async_reset();
        test_wide_lanes();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
